// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Definitions shared by the calculator blocks (keypad front end, FSM, ALU):
//   - OP_ADD/OP_SUB/OP_MUL/OP_DIV : 2-bit operator codes
//   - kp_state_t                  : keypad scanner FSM state encoding
//   - key_kind_t / key_entry_t    : decoded key class and value
//   - KEY_MAP                     : 16-entry key map indexed by {row, col}
//   - key_lookup()                : map lookup returning a key_entry_t
//   - lowest_low_row()            : priority pick of the lowest active-low row
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    KP_SCAN     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_EMIT     = 2'd2,
    KP_RELEASE  = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    KEY_NUM = 2'd0,
    KEY_OP  = 2'd1,
    KEY_EQ  = 2'd2,
    KEY_CLR = 2'd3
  } key_kind_t;

  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] val;   // BCD digit for KEY_NUM, {2'b00, op code} for KEY_OP
  } key_entry_t;

  // Layout (row0 at top):  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  localparam logic [5:0] KEY_MAP [16] = '{
    {KEY_NUM, 4'd1}, {KEY_NUM, 4'd2}, {KEY_NUM, 4'd3}, {KEY_OP, 2'b00, OP_ADD},
    {KEY_NUM, 4'd4}, {KEY_NUM, 4'd5}, {KEY_NUM, 4'd6}, {KEY_OP, 2'b00, OP_SUB},
    {KEY_NUM, 4'd7}, {KEY_NUM, 4'd8}, {KEY_NUM, 4'd9}, {KEY_OP, 2'b00, OP_MUL},
    {KEY_CLR, 4'd0}, {KEY_NUM, 4'd0}, {KEY_EQ, 4'd0},  {KEY_OP, 2'b00, OP_DIV}
  };

  function automatic key_entry_t key_lookup(input logic [1:0] row, input logic [1:0] col);
    return key_entry_t'(KEY_MAP[{row, col}]);
  endfunction

  // Returns {found, row index}; the lowest-numbered low row wins.
  function automatic logic [2:0] lowest_low_row(input logic [3:0] rows);
    logic [2:0] res;
    if (!rows[0]) begin
      res = {1'b1, 2'd0};
    end else if (!rows[1]) begin
      res = {1'b1, 2'd1};
    end else if (!rows[2]) begin
      res = {1'b1, 2'd2};
    end else if (!rows[3]) begin
      res = {1'b1, 2'd3};
    end else begin
      res = {1'b0, 2'd0};
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Two-flop synchroniser bringing the asynchronous keypad rows into clk domain.
// Ports:
//   clk  in  1      system clock
//   rst  in  1      asynchronous, active-high reset (flops go to RESET_VAL)
//   d    in  WIDTH  asynchronous input
//   q    out WIDTH  synchronised output
// -----------------------------------------------------------------------------
module keypad_sync #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Synchroniser chain; reset value matches the idle (pulled-up) rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 matrix keypad front end: scans the columns, synchronises and debounces
// the rows, and decodes each accepted keypress into one single-cycle event.
// Ports:
//   clk      in   1  system clock
//   rst      in   1  asynchronous, active-high reset
//   row_in   in   4  keypad rows, active-low, asynchronous to clk
//   col_out  out  4  column drive, one-hot active-low
//   is_num   out  1  pulse: digit key accepted (num_val valid)
//   is_op    out  1  pulse: operator key accepted (op_val valid)
//   is_eq    out  1  pulse: '#' accepted
//   is_clr   out  1  pulse: '*' accepted
//   num_val  out  4  BCD digit, held until the next digit event
//   op_val   out  2  operator code, held until the next operator event
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       is_num,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic [3:0] num_val,
  output logic [1:0] op_val
);

  import calc_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  kp_state_t        state_r, state_nxt_s;
  logic [1:0]       col_idx_r, col_idx_nxt_s;
  logic [1:0]       key_row_r, key_row_nxt_s;
  logic [1:0]       key_col_r, key_col_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             low_found_s;
  logic [1:0]       low_row_s;
  key_entry_t       key_s;
  logic [3:0]       col_out_nxt_s;
  logic             is_num_nxt_s, is_op_nxt_s, is_eq_nxt_s, is_clr_nxt_s;
  logic [3:0]       num_val_nxt_s;
  logic [1:0]       op_val_nxt_s;

  keypad_sync #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_sync)
  );

  assign {low_found_s, low_row_s} = lowest_low_row(row_sync);
  assign tick_s = (div_r == DIV_LAST);
  assign key_s  = key_lookup(key_row_r, key_col_r);

  // Free-running column dwell divider; tick marks the last cycle of a dwell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // FSM state and scan/debounce bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= KP_SCAN;
      col_idx_r <= 2'd0;
      key_row_r <= 2'd0;
      key_col_r <= 2'd0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      col_idx_r <= col_idx_nxt_s;
      key_row_r <= key_row_nxt_s;
      key_col_r <= key_col_nxt_s;
      cnt_r     <= cnt_nxt_s;
    end
  end

  // Next-state logic; all row decisions are taken on the scan tick only.
  always_comb begin
    state_nxt_s   = state_r;
    col_idx_nxt_s = col_idx_r;
    key_row_nxt_s = key_row_r;
    key_col_nxt_s = key_col_r;
    cnt_nxt_s     = cnt_r;
    case (state_r)
      KP_SCAN: begin
        if (tick_s) begin
          if (low_found_s) begin
            key_row_nxt_s = low_row_s;
            key_col_nxt_s = col_idx_r;
            cnt_nxt_s     = CNT_W'(1);
            state_nxt_s   = KP_DEBOUNCE;
          end else begin
            col_idx_nxt_s = col_idx_r + 2'd1;
          end
        end else begin
          state_nxt_s = KP_SCAN;
        end
      end
      KP_DEBOUNCE: begin
        if (tick_s) begin
          // Only the same row as the lowest active row counts as a stable sample.
          if (low_found_s && (low_row_s == key_row_r)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            if (cnt_r == CNT_LAST) begin
              state_nxt_s = KP_EMIT;
            end else begin
              state_nxt_s = KP_DEBOUNCE;
            end
          end else begin
            cnt_nxt_s     = '0;
            col_idx_nxt_s = col_idx_r + 2'd1;
            state_nxt_s   = KP_SCAN;
          end
        end else begin
          state_nxt_s = KP_DEBOUNCE;
        end
      end
      KP_EMIT: begin
        cnt_nxt_s   = '0;
        state_nxt_s = KP_RELEASE;
      end
      KP_RELEASE: begin
        if (tick_s) begin
          if (low_found_s) begin
            cnt_nxt_s = '0;
          end else if (cnt_r == CNT_LAST) begin
            cnt_nxt_s     = '0;
            col_idx_nxt_s = col_idx_r + 2'd1;
            state_nxt_s   = KP_SCAN;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = KP_RELEASE;
        end
      end
      default: begin
        cnt_nxt_s   = '0;
        state_nxt_s = KP_SCAN;
      end
    endcase
  end

  // Output decode; pulses are prepared on entry to EMIT so they register high
  // exactly during the EMIT cycle.
  always_comb begin
    col_out_nxt_s = ~(4'b0001 << col_idx_nxt_s);
    is_num_nxt_s  = 1'b0;
    is_op_nxt_s   = 1'b0;
    is_eq_nxt_s   = 1'b0;
    is_clr_nxt_s  = 1'b0;
    num_val_nxt_s = num_val;
    op_val_nxt_s  = op_val;
    if (state_nxt_s == KP_EMIT) begin
      case (key_s.kind)
        KEY_NUM: begin
          is_num_nxt_s  = 1'b1;
          num_val_nxt_s = key_s.val;
        end
        KEY_OP: begin
          is_op_nxt_s  = 1'b1;
          op_val_nxt_s = key_s.val[1:0];
        end
        KEY_EQ:  is_eq_nxt_s  = 1'b1;
        KEY_CLR: is_clr_nxt_s = 1'b1;
        default: is_clr_nxt_s = 1'b0;
      endcase
    end else begin
      is_num_nxt_s = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_out <= 4'b1110;
      is_num  <= 1'b0;
      is_op   <= 1'b0;
      is_eq   <= 1'b0;
      is_clr  <= 1'b0;
      num_val <= 4'd0;
      op_val  <= 2'd0;
    end else begin
      col_out <= col_out_nxt_s;
      is_num  <= is_num_nxt_s;
      is_op   <= is_op_nxt_s;
      is_eq   <= is_eq_nxt_s;
      is_clr  <= is_clr_nxt_s;
      num_val <= num_val_nxt_s;
      op_val  <= op_val_nxt_s;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Self-checking bench: a keypad model drives row_in from col_out and the set of
// pressed keys; observed events are compared with events derived from the key
// layout rules.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       is_num, is_op, is_eq, is_clr;
  logic [3:0] num_val;
  logic [1:0] op_val;

  logic [15:0] keys = 16'h0000;   // bit index = row*4 + col
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [5:0]  got_q [$];         // {kind, val}: kind 0 num, 1 op, 2 eq, 3 clr
  int          got_cyc [$];
  logic [5:0]  exp_q [$];
  logic [3:0]  exp_col;
  logic [3:0]  prev_col;
  bit          found;
  int          idx;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .is_num  (is_num),
    .is_op   (is_op),
    .is_eq   (is_eq),
    .is_clr  (is_clr),
    .num_val (num_val),
    .op_val  (op_val)
  );

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Cycles since reset release.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    int n;
    n = int'(is_num) + int'(is_op) + int'(is_eq) + int'(is_clr);
    if (n != 0) begin
      check("one_pulse", n, 1);
      if (is_num)     got_q.push_back({2'd0, num_val});
      else if (is_op) got_q.push_back({2'd1, 2'b00, op_val});
      else if (is_eq) got_q.push_back({2'd2, 4'd0});
      else            got_q.push_back({2'd3, 4'd0});
      got_cyc.push_back(cyc);
    end
  end

  // Reference key meaning from the keypad layout.
  function automatic logic [5:0] ref_key(input int k);
    int r, c;
    r = k / 4;
    c = k % 4;
    if (c == 3) return {2'd1, 4'(r)};
    if (r < 3)  return {2'd0, 4'(r*3 + c + 1)};
    if (c == 0) return {2'd3, 4'd0};
    if (c == 1) return {2'd0, 4'd0};
    return {2'd2, 4'd0};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_events(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
    check("event_wait", got_q.size() >= n, 1);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_kind"}, got_q[i][5:4], exp_q[i][5:4]);
      check({tag, "_val"},  got_q[i][3:0], exp_q[i][3:0]);
    end
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col_out", col_out, 4'hE);
    check("rst_pulses", {is_num, is_op, is_eq, is_clr}, 4'h0);
    check("rst_num_val", num_val, 4'd0);
    check("rst_op_val", op_val, 2'd0);

    // Idle column rotation, one column per SCAN_DIV cycles
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check("rotate", col_out, exp_col);
      @(negedge clk);
    end

    // Asynchronous reset mid-scan
    wait_cycles(6);
    #3 rst = 1'b1;
    #1;
    check("midrst_col_out", col_out, 4'hE);
    check("midrst_pulses", {is_num, is_op, is_eq, is_clr}, 4'h0);

    // Hold '7' from reset: first tick at SCAN_DIV-1, then the spec latency
    keys[8] = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_events(1, 100);
    check("latency_7", (got_cyc.size() > 0) ? got_cyc[0] : -1,
          (SCAN_DIV - 1) + (DEBOUNCE_CNT - 1) * SCAN_DIV + 1);
    wait_cycles(80);
    exp_q.push_back(ref_key(8));
    compare_events("hold7");

    // Reset while '7' still held: re-detected once
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_events(1, 100);
    wait_cycles(60);
    exp_q.push_back(ref_key(8));
    compare_events("rst_hold7");
    keys = 16'h0000;
    wait_cycles(40);

    // 'C' then '#'
    keys[11] = 1'b1;
    wait_events(1, 200);
    keys = 16'h0000;
    wait_cycles(40);
    keys[14] = 1'b1;
    wait_events(2, 200);
    keys = 16'h0000;
    wait_cycles(40);
    exp_q.push_back(ref_key(11));
    exp_q.push_back(ref_key(14));
    compare_events("c_eq");

    // '5' low for exactly one tick of column 1
    found = 1'b0;
    prev_col = col_out;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (col_out == 4'hD && prev_col != 4'hD) found = 1'b1;
      else prev_col = col_out;
    end
    check("bounce_align", found, 1);
    keys[5] = 1'b1;
    wait_cycles(4);
    keys[5] = 1'b0;
    wait_cycles(3);
    check("bounce_col_held", col_out, 4'hD);
    wait_cycles(1);
    check("bounce_col_next", col_out, 4'hB);
    wait_cycles(40);
    compare_events("bounce5");

    // Hold '1', add '2', release both
    keys[0] = 1'b1;
    wait_events(1, 200);
    keys[1] = 1'b1;
    wait_cycles(40);
    keys = 16'h0000;
    wait_cycles(80);
    exp_q.push_back(ref_key(0));
    compare_events("two_keys");

    // Rows 0 and 2 on column 1 together: lowest row wins
    keys[1] = 1'b1;
    keys[9] = 1'b1;
    wait_events(1, 200);
    wait_cycles(10);
    keys = 16'h0000;
    wait_cycles(40);
    exp_q.push_back(ref_key(1));
    compare_events("multi_row");

    // Random single keypresses
    for (int it = 0; it < 20; it++) begin
      idx = int'($urandom_range(0, 15));
      keys[idx] = 1'b1;
      wait_events(1, 200);
      wait_cycles(int'($urandom_range(0, 30)));
      keys = 16'h0000;
      wait_cycles(int'($urandom_range(30, 60)));
      exp_q.push_back(ref_key(idx));
      compare_events("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
